pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- FLUSH_CYCLES, 2, cycles ID/EX is bubbled after a taken jump (range 1..7).
- LOAD_STALL, 1, bubble cycles inserted for a load-use hazard (range 1..7).
- MEM_TIMEOUT, 15, maximum MEMWAIT cycles before forced exit (range 1..255).

REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset.
- id_src1, id_src2  in  5 each  source register indices of the ID-stage instruction.
- id_use1, id_use2  in  1 each  ID instruction reads src1/src2.
- ex_control  in  5  EX-stage control; bits[3:0] are the opcode, bit 4 is ignored.
- ex_dest_index  in  5  EX destination index.
- ex_write_en  in  1  EX instruction writes a register.
- ex_branch_taken  in  1  EX jump resolved taken this cycle.
- mem_req  in  1  MEM stage starting LOAD/STORE access.
- mem_ack  in  1  memory access complete.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  pipeline register enables.
- flush_if_id, flush_id_ex  out  1 each  load NOP into that register.
- pc_sel_target  out  1  PC loads EX target.
- state  out  2  current FSM state.
- mem_timeout  out  1  sticky timeout flag.
- stall_cnt  out  16  saturating count of stalled cycles.

REQ-003 The block SHALL use one clock, clk, with an asynchronous, active-low reset, rst_n.

Function
REQ-004 The FSM SHALL have four states: RUN=0, LDSTALL=1, FLUSH=2, MEMWAIT=3.
REQ-005 All outputs (enables, flush, pc_sel_target) SHALL be combinational from the state, the counters and the inputs; the state, counters and flags SHALL be registered.
REQ-006 In RUN with no event, all four enables SHALL be 1 and the flushes and pc_sel_target SHALL be 0.
REQ-007 A MEM stall occurs when mem_req=1 and mem_ack=0. It has top priority in any non-MEMWAIT state:
- all enables 0, no flush, pc_sel_target 0;
- the current state and remaining count are saved;
- next state is MEMWAIT.
REQ-008 A mem_req and mem_ack in the same cycle SHALL cause no stall.
REQ-009 MEMWAIT behaviour:
- all enables stay 0, and a wait counter increments;
- mem_ack=1 returns to the saved state with the saved count, with enables per that state in that cycle;
- if the counter reaches MEM_TIMEOUT with no ack, mem_timeout is set (sticky) and the block returns to the saved state.
REQ-010 A taken branch (ex_branch_taken=1 in RUN/LDSTALL, no MEM stall) SHALL produce, in that cycle, pc_sel_target=1, flush_if_id=1 and flush_id_ex=1, with all enables 1.
REQ-011 After a taken branch, the block SHALL enter FLUSH with count FLUSH_CYCLES-1, or stay in RUN if FLUSH_CYCLES=1.
REQ-012 A taken branch SHALL override load-use and cancel LDSTALL.
REQ-013 In FLUSH, flush_id_ex SHALL be 1, the other enables 1, and the count decrements; at count 1 the next state is RUN.
REQ-014 In FLUSH, ex_branch_taken SHALL be ignored (the EX instruction is a bubble).
REQ-015 A load-use hazard is: ex_control[3:0]=LOAD, ex_write_en=1, and (id_use1 with id_src1==ex_dest_index, or id_use2 with id_src2==ex_dest_index). All indices, including 0, are compared.
REQ-016 On a load-use hazard in RUN: pc_en=0, if_id_en=0, flush_id_ex=1, ex_mem_en=1; next state is LDSTALL with count LOAD_STALL-1, or RUN if LOAD_STALL=1.
REQ-017 In LDSTALL, the RUN load-use outputs SHALL be held and the count decrements; at count 1 the next state is RUN.
REQ-018 stall_cnt SHALL increment in every cycle with pc_en=0 and saturate at 16'hFFFF.

Reset
REQ-019 While rst_n=0, the block SHALL be in RUN, with all counters 0, mem_timeout=0, stall_cnt=0 and saved state RUN.
REQ-020 During reset, the outputs SHALL take the RUN values.
REQ-021 Reset asserted mid-MEMWAIT or mid-FLUSH SHALL abandon the operation immediately, and the saved state is discarded.

Structure
REQ-022 The opcode constants (NOP..MOV, 4-bit, LOAD=4'b1100, jumps 4'b0110..4'b1010) and the state encoding SHALL live in the shared package pipe_pkg, which the execute stage also uses.
REQ-023 The hazard comparator SHALL be a sub-module, hazard_detect (combinational load-use detect); the rest is flat.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Load-use: ex_control=LOAD, ex_dest_index=3, ex_write_en=1, id_src2=3, id_use2=1 -> one cycle of pc_en=0, if_id_en=0, flush_id_ex=1, then RUN; stall_cnt=1.
- Taken jump: ex_branch_taken=1 -> pc_sel_target=1 and both flushes for 1 cycle, then 1 FLUSH cycle with flush_id_ex=1; state 0->2->0.
- Branch and load-use in the same cycle -> branch response only; stall_cnt unchanged.
- mem_req=1, mem_ack low for 4 cycles, issued during FLUSH -> enables 0 for 4 cycles, then FLUSH resumes with its remaining count; stall_cnt +4.
- mem_ack never asserted -> mem_timeout=1 after exactly 15 MEMWAIT cycles, return to RUN, flag persists until rst_n=0.
- rst_n pulsed low mid-MEMWAIT -> state=0, mem_timeout=0, stall_cnt=0 asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode map, controller state encoding and the
// bundle of pipeline enable/flush controls driven by pipe_ctrl.
package pipe_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'b0000, OP_ADD   = 4'b0001, OP_SUB   = 4'b0010, OP_AND  = 4'b0011,
    OP_OR    = 4'b0100, OP_XOR   = 4'b0101, OP_JMP   = 4'b0110, OP_JZ   = 4'b0111,
    OP_JNZ   = 4'b1000, OP_JC    = 4'b1001, OP_JNC   = 4'b1010, OP_CMP  = 4'b1011,
    OP_LOAD  = 4'b1100, OP_STORE = 4'b1101, OP_SHL   = 4'b1110, OP_MOV  = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_MEMWAIT = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic flush_if_id;
    logic flush_id_ex;
    logic pc_sel_target;
  } ctl_t;

  localparam ctl_t CTL_RUN    = 7'b1111_000;
  localparam ctl_t CTL_HOLD   = 7'b0000_000;
  localparam ctl_t CTL_BRANCH = 7'b1111_111;
  localparam ctl_t CTL_FLUSH  = 7'b1111_010;
  localparam ctl_t CTL_LDUSE  = 7'b0011_010;

  function automatic logic is_jump(input logic [3:0] op);
    return (op >= OP_JMP) && (op <= OP_JNC);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the EX load writes a register the ID instruction reads.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_src1_i,
  input  logic [4:0] id_src2_i,
  input  logic       id_use1_i,
  input  logic       id_use2_i,
  input  logic [3:0] ex_op_i,
  input  logic [4:0] ex_dest_i,
  input  logic       ex_write_en_i,
  output logic       load_use_o
);

  // Register 0 is compared like any other index.
  assign load_use_o = (ex_op_i == OP_LOAD) && ex_write_en_i &&
                      ((id_use1_i && (id_src1_i == ex_dest_i)) ||
                       (id_use2_i && (id_src2_i == ex_dest_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-jump flushes and memory
// wait stalls with timeout, plus a saturating stalled-cycle counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_STALL   = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_src1,
  input  logic [4:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [4:0]  ex_control,
  input  logic [4:0]  ex_dest_index,
  input  logic        ex_write_en,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        pc_sel_target,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LD_INIT    = 3'(LOAD_STALL - 1);
  localparam logic [7:0] TMO_LAST   = 8'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d, saved_q, saved_d, eff_state;
  logic [2:0]  cnt_q, cnt_d, saved_cnt_q, saved_cnt_d, eff_cnt;
  logic [7:0]  wait_q, wait_d;
  logic        tmo_q, tmo_d;
  logic [15:0] stall_q, stall_d;
  logic        load_use, mem_stall;
  ctl_t        ctl;
  logic        unused_ex_ctl;

  assign unused_ex_ctl = ex_control[4];
  assign mem_stall     = mem_req & ~mem_ack;

  hazard_detect u_hazard (
    .id_src1_i     (id_src1),
    .id_src2_i     (id_src2),
    .id_use1_i     (id_use1),
    .id_use2_i     (id_use2),
    .ex_op_i       (ex_control[3:0]),
    .ex_dest_i     (ex_dest_index),
    .ex_write_en_i (ex_write_en),
    .load_use_o    (load_use)
  );

  always_comb begin
    ctl         = CTL_RUN;
    state_d     = state_q;
    cnt_d       = cnt_q;
    saved_d     = saved_q;
    saved_cnt_d = saved_cnt_q;
    wait_d      = wait_q;
    tmo_d       = tmo_q;
    eff_state   = state_q;
    eff_cnt     = cnt_q;

    // The ack cycle already behaves as the resumed state (outputs and transition).
    if (state_q == ST_MEMWAIT) begin
      if (mem_ack) begin
        eff_state = saved_q;
        eff_cnt   = saved_cnt_q;
      end else begin
        ctl    = CTL_HOLD;
        wait_d = wait_q + 8'd1;
        if (wait_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = saved_q;
          cnt_d   = saved_cnt_q;
        end
      end
    end

    if (state_q != ST_MEMWAIT || mem_ack) begin
      state_d = ST_RUN;
      cnt_d   = 3'd0;
      if (mem_stall) begin
        ctl         = CTL_HOLD;
        saved_d     = eff_state;
        saved_cnt_d = eff_cnt;
        wait_d      = 8'd0;
        state_d     = ST_MEMWAIT;
        cnt_d       = eff_cnt;
      end else if (eff_state == ST_FLUSH) begin
        ctl = CTL_FLUSH;
        if (eff_cnt > 3'd1) begin
          state_d = ST_FLUSH;
          cnt_d   = eff_cnt - 3'd1;
        end
      end else if (ex_branch_taken) begin
        ctl = CTL_BRANCH;
        if (FLUSH_CYCLES > 1) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_INIT;
        end
      end else if (eff_state == ST_LDSTALL) begin
        ctl = CTL_LDUSE;
        if (eff_cnt > 3'd1) begin
          state_d = ST_LDSTALL;
          cnt_d   = eff_cnt - 3'd1;
        end
      end else if (load_use) begin
        ctl = CTL_LDUSE;
        if (LOAD_STALL > 1) begin
          state_d = ST_LDSTALL;
          cnt_d   = LD_INIT;
        end
      end
    end

    if (!rst_n) ctl = CTL_RUN;
    stall_d = (!ctl.pc_en && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= 3'd0;
      saved_q     <= ST_RUN;
      saved_cnt_q <= 3'd0;
      wait_q      <= 8'd0;
      tmo_q       <= 1'b0;
      stall_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      saved_q     <= saved_d;
      saved_cnt_q <= saved_cnt_d;
      wait_q      <= wait_d;
      tmo_q       <= tmo_d;
      stall_q     <= stall_d;
    end
  end

  assign pc_en         = ctl.pc_en;
  assign if_id_en      = ctl.if_id_en;
  assign id_ex_en      = ctl.id_ex_en;
  assign ex_mem_en     = ctl.ex_mem_en;
  assign flush_if_id   = ctl.flush_if_id;
  assign flush_id_ex   = ctl.flush_id_ex;
  assign pc_sel_target = ctl.pc_sel_target;
  assign state         = state_q;
  assign mem_timeout   = tmo_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus a randomized run checked
// against a remaining-cycles reference model.
module tb_pipe_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int LOAD_STALL   = 1;
  localparam int MEM_TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_src1, id_src2, ex_control, ex_dest_index;
  logic        id_use1, id_use2, ex_write_en, ex_branch_taken, mem_req, mem_ack;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex, pc_sel_target;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [15:0] stall_cnt;
  logic [6:0]  ctl;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: pending bubble cycles and memory wait bookkeeping.
  int m_flush, m_ld, m_wait_n, m_stalls;
  bit m_waiting, m_tmo;

  always #5 clk = ~clk;

  assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, flush_if_id, flush_id_ex, pc_sel_target};

  pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .LOAD_STALL(LOAD_STALL), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_control(ex_control), .ex_dest_index(ex_dest_index), .ex_write_en(ex_write_en),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .pc_sel_target(pc_sel_target),
    .state(state), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  task automatic clear_inputs();
    id_src1 = 0; id_src2 = 0; id_use1 = 0; id_use2 = 0;
    ex_control = 0; ex_dest_index = 0; ex_write_en = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    ex_branch_taken = 1; mem_req = 1; ex_control = 5'h0C; ex_write_en = 1; id_use1 = 1;
    #2;
    n_total++;
    if ({ctl, state, mem_timeout, stall_cnt} !== {7'b1111000, 2'd0, 1'b0, 16'd0})
      $display("FAIL reset_outputs: got ctl=%b st=%0d tmo=%b stall=%0d want ctl=1111000 st=0 tmo=0 stall=0",
               ctl, state, mem_timeout, stall_cnt);
    else n_pass++;
    clear_inputs();
    tick();
    rst_n = 1;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_control = 5'h1C; ex_dest_index = 3; ex_write_en = 1;
    id_src2 = 3; id_use2 = 1; id_src1 = 7; id_use1 = 1;
    @(negedge clk);
    n_total++;
    if ({ctl, state} !== {7'b0011010, 2'd0})
      $display("FAIL load_use_bubble: got ctl=%b st=%0d want ctl=0011010 st=0", ctl, state);
    else n_pass++;
    tick();
    clear_inputs();
    @(negedge clk);
    n_total++;
    if ({ctl, state, stall_cnt} !== {7'b1111000, 2'd0, 16'd1})
      $display("FAIL load_use_after: got ctl=%b st=%0d stall=%0d want ctl=1111000 st=0 stall=1",
               ctl, state, stall_cnt);
    else n_pass++;
    tick();
    ex_control = 5'h0C; ex_write_en = 1; ex_dest_index = 0; id_src1 = 0; id_use1 = 1;
    @(negedge clk);
    n_total++;
    if (pc_en !== 1'b0) $display("FAIL load_use_reg0: got pc_en=%b want 0", pc_en);
    else n_pass++;
    tick();
    id_use1 = 0;
    @(negedge clk);
    n_total++;
    if (pc_en !== 1'b1) $display("FAIL load_use_unused_src: got pc_en=%b want 1", pc_en);
    else n_pass++;
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1;
    @(negedge clk);
    n_total++;
    if ({ctl, state} !== {7'b1111111, 2'd0})
      $display("FAIL branch_cycle: got ctl=%b st=%0d want ctl=1111111 st=0", ctl, state);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if ({ctl, state} !== {7'b1111010, 2'd2})
      $display("FAIL branch_flush: got ctl=%b st=%0d want ctl=1111010 st=2", ctl, state);
    else n_pass++;
    tick();
    ex_branch_taken = 0;
    @(negedge clk);
    n_total++;
    if ({ctl, state, stall_cnt} !== {7'b1111000, 2'd0, 16'd0})
      $display("FAIL branch_done: got ctl=%b st=%0d stall=%0d want ctl=1111000 st=0 stall=0",
               ctl, state, stall_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_branch_loaduse();
    do_reset();
    ex_branch_taken = 1; ex_control = 5'h0C; ex_dest_index = 5; ex_write_en = 1;
    id_src1 = 5; id_use1 = 1;
    @(negedge clk);
    n_total++;
    if (ctl !== 7'b1111111)
      $display("FAIL branch_over_loaduse: got ctl=%b want 1111111", ctl);
    else n_pass++;
    tick();
    clear_inputs();
    @(negedge clk);
    n_total++;
    if ({state, stall_cnt} !== {2'd2, 16'd0})
      $display("FAIL branch_over_loaduse_next: got st=%0d stall=%0d want st=2 stall=0", state, stall_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_mem_in_flush();
    do_reset();
    ex_branch_taken = 1;
    tick();
    ex_branch_taken = 0; mem_req = 1;
    @(negedge clk);
    n_total++;
    if ({ctl, state} !== {7'b0000000, 2'd2})
      $display("FAIL mem_stall_entry: got ctl=%b st=%0d want ctl=0000000 st=2", ctl, state);
    else n_pass++;
    tick();
    mem_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({ctl, state} !== {7'b0000000, 2'd3})
        $display("FAIL mem_wait_%0d: got ctl=%b st=%0d want ctl=0000000 st=3", i, ctl, state);
      else n_pass++;
      tick();
    end
    mem_ack = 1;
    @(negedge clk);
    n_total++;
    if (ctl !== 7'b1111010)
      $display("FAIL mem_ack_resume_flush: got ctl=%b want 1111010", ctl);
    else n_pass++;
    tick();
    mem_ack = 0;
    @(negedge clk);
    n_total++;
    if ({ctl, state, stall_cnt} !== {7'b1111000, 2'd0, 16'd4})
      $display("FAIL mem_after_flush: got ctl=%b st=%0d stall=%0d want ctl=1111000 st=0 stall=4",
               ctl, state, stall_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1;
    tick();
    mem_req = 0;
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      @(negedge clk);
      n_total++;
      if ({state, mem_timeout, pc_en} !== {2'd3, 1'b0, 1'b0})
        $display("FAIL timeout_wait_%0d: got st=%0d tmo=%b pc_en=%b want st=3 tmo=0 pc_en=0",
                 k, state, mem_timeout, pc_en);
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_total++;
    if ({state, mem_timeout, ctl, stall_cnt} !== {2'd0, 1'b1, 7'b1111000, 16'd16})
      $display("FAIL timeout_exit: got st=%0d tmo=%b ctl=%b stall=%0d want st=0 tmo=1 ctl=1111000 stall=16",
               state, mem_timeout, ctl, stall_cnt);
    else n_pass++;
    ex_branch_taken = 1;
    repeat (4) tick();
    ex_branch_taken = 0;
    @(negedge clk);
    n_total++;
    if (mem_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", mem_timeout);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_memwait();
    do_reset();
    mem_req = 1;
    tick();
    mem_req = 0;
    repeat (MEM_TIMEOUT + 1) tick();
    mem_req = 1;
    tick();
    mem_req = 0;
    repeat (3) tick();
    n_total++;
    if ({state, mem_timeout} !== {2'd3, 1'b1})
      $display("FAIL pre_reset_wait: got st=%0d tmo=%b want st=3 tmo=1", state, mem_timeout);
    else n_pass++;
    #2 rst_n = 0;
    #1;
    n_total++;
    if ({state, mem_timeout, stall_cnt, ctl} !== {2'd0, 1'b0, 16'd0, 7'b1111000})
      $display("FAIL async_reset_memwait: got st=%0d tmo=%b stall=%0d ctl=%b want st=0 tmo=0 stall=0 ctl=1111000",
               state, mem_timeout, stall_cnt, ctl);
    else n_pass++;
    tick();
    rst_n = 1;
    @(negedge clk);
    n_total++;
    if ({state, ctl} !== {2'd0, 7'b1111000})
      $display("FAIL reset_discards_saved: got st=%0d ctl=%b want st=0 ctl=1111000", state, ctl);
    else n_pass++;
    tick();
  endtask

  task automatic model_reset();
    m_flush = 0; m_ld = 0; m_wait_n = 0; m_stalls = 0; m_waiting = 0; m_tmo = 0;
  endtask

  task automatic model_step(output logic [6:0] e_ctl);
    bit mstall, haz;
    mstall = mem_req && !mem_ack;
    haz = (ex_control[3:0] == 4'd12) && ex_write_en &&
          ((id_use1 && id_src1 == ex_dest_index) || (id_use2 && id_src2 == ex_dest_index));
    e_ctl = 7'b1111000;
    if (m_waiting && !mem_ack) begin
      e_ctl = 7'b0000000;
      m_wait_n++;
      if (m_wait_n == MEM_TIMEOUT) begin
        m_tmo = 1;
        m_waiting = 0;
      end
    end else if (!m_waiting && mstall) begin
      e_ctl = 7'b0000000;
      m_waiting = 1;
      m_wait_n = 0;
    end else begin
      m_waiting = 0;
      if (m_flush > 0) begin
        e_ctl = 7'b1111010;
        m_flush--;
      end else if (ex_branch_taken) begin
        e_ctl = 7'b1111111;
        m_flush = FLUSH_CYCLES - 1;
        m_ld = 0;
      end else if (m_ld > 0) begin
        e_ctl = 7'b0011010;
        m_ld--;
      end else if (haz) begin
        e_ctl = 7'b0011010;
        m_ld = LOAD_STALL - 1;
      end
    end
    if (!e_ctl[6] && m_stalls < 65535) m_stalls++;
  endtask

  task automatic test_random();
    logic [6:0] e_ctl;
    logic [1:0] e_state;
    bit         e_tmo;
    int         e_stalls;
    int         ack_div;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      ack_div = (c < 400) ? 3 : 20;
      mem_req         = ($urandom_range(0, 7) == 0);
      mem_ack         = ($urandom_range(0, ack_div) == 0);
      ex_branch_taken = ($urandom_range(0, 6) == 0);
      ex_control      = ($urandom_range(0, 1) == 1) ? {1'($urandom), 4'hC} : 5'($urandom);
      ex_write_en     = 1'($urandom);
      ex_dest_index   = 5'($urandom_range(0, 3));
      id_src1         = 5'($urandom_range(0, 3));
      id_src2         = 5'($urandom_range(0, 3));
      id_use1         = 1'($urandom);
      id_use2         = 1'($urandom);
      e_state  = m_waiting ? 2'd3 : (m_flush > 0) ? 2'd2 : (m_ld > 0) ? 2'd1 : 2'd0;
      e_tmo    = m_tmo;
      e_stalls = m_stalls;
      model_step(e_ctl);
      @(negedge clk);
      n_total++;
      if ({ctl, state, mem_timeout, stall_cnt} !== {e_ctl, e_state, e_tmo, 16'(e_stalls)})
        $display("FAIL random_c%0d: got ctl=%b st=%0d tmo=%b stall=%0d want ctl=%b st=%0d tmo=%b stall=%0d",
                 c, ctl, state, mem_timeout, stall_cnt, e_ctl, e_state, e_tmo, e_stalls);
      else n_pass++;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_branch_loaduse();
    test_mem_in_flush();
    test_timeout();
    test_reset_memwait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
